uart_loader: RTL and testbench

- Downstream consumer of the UART receiver's byte stream (valid strobe plus byte).
- Parses framed binary load packets and issues single-cycle byte writes into the machine's memory/RAM port.
- Verifies a per-frame checksum, aborts stalled frames on an inter-byte timeout, and reports status.
- Writes stream through as data bytes arrive. Checksum result is reported after the frame; rejected frames are not rolled back.

---
 rtl/uart_loader_pkg.sv | 22 ++
 rtl/uart_loader_timeout.sv | 28 ++
 rtl/uart_loader.sv | 170 +++++++++++++++++
 tb/tb_uart_loader.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared state encoding, protocol byte values and helpers for the uart_loader frame parser.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_HI = 3'd1,
    S_ADDR_LO = 3'd2,
    S_LEN     = 3'd3,
    S_DATA    = 3'd4,
    S_CHK     = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  // A LEN byte of zero encodes a full 256-byte payload.
  function automatic logic [8:0] len_to_count(input logic [7:0] len);
    return (len == 8'h00) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/uart_loader_timeout.sv
// Inter-byte timeout counter for uart_loader: clears on request, counts while enabled,
// and stops at its terminal count of TIMEOUT_CLKS-1.
module uart_loader_timeout #(
  parameter int TIMEOUT_CLKS = 434000
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Terminal
);

  localparam int CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] TERM_COUNT = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] r_Count;

  always_ff @(posedge i_Clock) begin
    if (i_Reset || i_Clear) begin
      r_Count <= '0;
    end else if (i_Enable && !o_Terminal) begin
      r_Count <= r_Count + CNT_W'(1);
    end
  end

  assign o_Terminal = (r_Count == TERM_COUNT);

endmodule

// File: rtl/uart_loader.sv
// Framed binary loader fed by a UART receiver: streams DATA bytes to a memory write port,
// checks the frame checksum and aborts on inter-byte timeout. Define UART_LOADER_ACK_EN for ACK/NAK replies.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 434000,
  parameter int ADDR_W       = 16
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Rx_DV,
  input  logic [7:0]        i_Rx_Byte,
`ifdef UART_LOADER_ACK_EN
  input  logic              i_Tx_Active,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
`endif
  output logic              o_Wr_En,
  output logic [ADDR_W-1:0] o_Wr_Addr,
  output logic [7:0]        o_Wr_Data,
  output logic              o_Busy,
  output logic              o_Frame_Ok,
  output logic              o_Frame_Err,
  output logic [7:0]        o_Err_Count
);

  state_t            r_State;
  logic [7:0]        r_Addr_Hi;
  logic [ADDR_W-1:0] r_Addr;
  logic [8:0]        r_Count;
  logic [7:0]        r_Sum;
  logic              r_Wr_En;
  logic [ADDR_W-1:0] r_Wr_Addr;
  logic [7:0]        r_Wr_Data;
  logic              r_Frame_Ok;
  logic              r_Frame_Err;
  logic [7:0]        r_Err_Count;

  logic       w_Idle;
  logic [7:0] w_Next_Sum;
  logic       w_Timeout;
  logic       w_Tmo_Clear;
  logic       w_Frame_Ok;
  logic       w_Frame_Err;

  assign w_Idle      = (r_State == S_IDLE);
  assign w_Next_Sum  = r_Sum + i_Rx_Byte;
  assign w_Tmo_Clear = i_Rx_DV || w_Idle;

  // A strobe arriving on the terminal-count cycle wins over the timeout abort.
  assign w_Frame_Ok  = i_Rx_DV && (r_State == S_CHK) && (w_Next_Sum == 8'h00);
  assign w_Frame_Err = (i_Rx_DV && (r_State == S_CHK) && (w_Next_Sum != 8'h00)) ||
                       (!i_Rx_DV && !w_Idle && w_Timeout);

  uart_loader_timeout #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_Clear   (w_Tmo_Clear),
    .i_Enable  (!w_Idle),
    .o_Terminal(w_Timeout)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State     <= S_IDLE;
      r_Addr_Hi   <= '0;
      r_Addr      <= '0;
      r_Count     <= '0;
      r_Sum       <= '0;
      r_Wr_En     <= 1'b0;
      r_Wr_Addr   <= '0;
      r_Wr_Data   <= '0;
      r_Frame_Ok  <= 1'b0;
      r_Frame_Err <= 1'b0;
      r_Err_Count <= '0;
    end else begin
      r_Wr_En     <= 1'b0;
      r_Frame_Ok  <= w_Frame_Ok;
      r_Frame_Err <= w_Frame_Err;
      if (w_Frame_Err && (r_Err_Count != 8'hFF)) begin
        r_Err_Count <= r_Err_Count + 8'd1;
      end
      if (i_Rx_DV) begin
        case (r_State)
          S_IDLE: begin
            if (i_Rx_Byte == SYNC_BYTE) begin
              r_Sum   <= '0;
              r_State <= S_ADDR_HI;
            end
          end
          S_ADDR_HI: begin
            r_Addr_Hi <= i_Rx_Byte;
            r_Sum     <= w_Next_Sum;
            r_State   <= S_ADDR_LO;
          end
          S_ADDR_LO: begin
            r_Addr  <= ADDR_W'({r_Addr_Hi, i_Rx_Byte});
            r_Sum   <= w_Next_Sum;
            r_State <= S_LEN;
          end
          S_LEN: begin
            r_Count <= len_to_count(i_Rx_Byte);
            r_Sum   <= w_Next_Sum;
            r_State <= S_DATA;
          end
          S_DATA: begin
            r_Wr_En   <= 1'b1;
            r_Wr_Addr <= r_Addr;
            r_Wr_Data <= i_Rx_Byte;
            r_Addr    <= r_Addr + ADDR_W'(1);
            r_Sum     <= w_Next_Sum;
            r_Count   <= r_Count - 9'd1;
            if (r_Count == 9'd1) begin
              r_State <= S_CHK;
            end
          end
          S_CHK: begin
            r_Sum   <= w_Next_Sum;
            r_State <= S_IDLE;
          end
          default: r_State <= S_IDLE;
        endcase
      end else if (w_Frame_Err) begin
        r_State <= S_IDLE;
      end
    end
  end

  assign o_Wr_En     = r_Wr_En;
  assign o_Wr_Addr   = r_Wr_Addr;
  assign o_Wr_Data   = r_Wr_Data;
  assign o_Busy      = !w_Idle;
  assign o_Frame_Ok  = r_Frame_Ok;
  assign o_Frame_Err = r_Frame_Err;
  assign o_Err_Count = r_Err_Count;

`ifdef UART_LOADER_ACK_EN
  logic       r_Pending;
  logic [7:0] r_Pend_Byte;
  logic       r_Tx_DV;
  logic [7:0] r_Tx_Byte;

  // A reply raised in the same cycle an older one is sent becomes the new pending reply.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Pending   <= 1'b0;
      r_Pend_Byte <= '0;
      r_Tx_DV     <= 1'b0;
      r_Tx_Byte   <= '0;
    end else begin
      r_Tx_DV <= 1'b0;
      if (r_Pending && !i_Tx_Active) begin
        r_Tx_DV   <= 1'b1;
        r_Tx_Byte <= r_Pend_Byte;
        r_Pending <= 1'b0;
      end
      if (w_Frame_Ok || w_Frame_Err) begin
        r_Pending   <= 1'b1;
        r_Pend_Byte <= w_Frame_Ok ? ACK_BYTE : NAK_BYTE;
      end
    end
  end

  assign o_Tx_DV   = r_Tx_DV;
  assign o_Tx_Byte = r_Tx_Byte;
`endif

endmodule

// File: tb/tb_uart_loader.sv
// Randomized scoreboard bench for uart_loader; a frame-level reference model predicts
// writes and status pulses with their cycle, and a monitor compares as the DUT emits them.
module tb_uart_loader;

  localparam int T = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        dv;
  logic [7:0]  rxByte;
  logic        wrEn;
  logic [15:0] wrAddr;
  logic [7:0]  wrData;
  logic        busy;
  logic        frameOk;
  logic        frameErr;
  logic [7:0]  errCount;
`ifdef UART_LOADER_ACK_EN
  logic        txActive;
  logic        txDv;
  logic [7:0]  txByte;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_loader #(
    .TIMEOUT_CLKS(T),
    .ADDR_W      (16)
  ) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_Rx_DV    (dv),
    .i_Rx_Byte  (rxByte),
`ifdef UART_LOADER_ACK_EN
    .i_Tx_Active(txActive),
    .o_Tx_DV    (txDv),
    .o_Tx_Byte  (txByte),
`endif
    .o_Wr_En    (wrEn),
    .o_Wr_Addr  (wrAddr),
    .o_Wr_Data  (wrData),
    .o_Busy     (busy),
    .o_Frame_Ok (frameOk),
    .o_Frame_Err(frameErr),
    .o_Err_Count(errCount)
  );

  // kind: 0 = memory write, 1 = frame ok, 2 = frame error; cyc = edge after which it is visible
  typedef struct {
    int kind;
    int cyc;
    int addr;
    int data;
  } ev_t;

  ev_t expQ[$];
  ev_t txQ[$];

  int vectors = 0;
  int miscompares = 0;

  bit mInFrame = 1'b0;
  int mIdx, mAddr, mLen, mSum, mLastCyc;
  int mErrCnt = 0;

  logic [7:0] frameData[$];

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushEv(input int kind, input int c, input int a, input int d);
    ev_t ev;
    ev.kind = kind; ev.cyc = c; ev.addr = a; ev.data = d;
    expQ.push_back(ev);
    if (kind == 2 && mErrCnt < 255) mErrCnt++;
`ifdef UART_LOADER_ACK_EN
    if (kind != 0) begin
      ev.kind = 3; ev.cyc = c + 1; ev.addr = 0;
      ev.data = (kind == 1) ? 32'h06 : 32'h15;
      txQ.push_back(ev);
    end
`endif
  endtask

  // Frame-position model: byte index k after SYNC decides its role in the frame.
  task automatic modelByte(input logic [7:0] b, input int e);
    if (!mInFrame) begin
      if (b == 8'hA5) begin
        mInFrame = 1'b1; mIdx = 0; mSum = 0;
      end
    end else begin
      mIdx++;
      mSum = (mSum + int'(b)) % 256;
      if (mIdx == 1)             mAddr = int'(b) * 256;
      else if (mIdx == 2)        mAddr = mAddr + int'(b);
      else if (mIdx == 3)        mLen = (b == 8'h00) ? 256 : int'(b);
      else if (mIdx <= 3 + mLen) pushEv(0, e, (mAddr + mIdx - 4) % 65536, int'(b));
      else begin
        pushEv((mSum == 0) ? 1 : 2, e, 0, 0);
        mInFrame = 1'b0;
      end
    end
    mLastCyc = e;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    dv = 1'b1;
    rxByte = b;
    modelByte(b, cyc + 1);
  endtask

  task automatic applyIdle(input int k);
    repeat (k) begin
      @(negedge clk);
      dv = 1'b0;
      if (mInFrame && (cyc + 1 == mLastCyc + T)) begin
        mInFrame = 1'b0;
        pushEv(2, cyc + 1, 0, 0);
      end
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    dv = 1'b0;
    mInFrame = 1'b0;
    mErrCnt = 0;
    txQ.delete();
    @(negedge clk);
    checkOutput("busy_after_reset", int'(busy), 0);
    checkOutput("errcnt_after_reset", int'(errCount), 0);
    rst = 1'b0;
  endtask

  task automatic fillData(input int n);
    frameData.delete();
    for (int i = 0; i < n; i++) frameData.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic sendFrame(input logic [15:0] addr, input logic [7:0] len, input int corrupt,
                           input int maxGap, input int syncGap);
    int n;
    int sum;
    n = (len == 8'h00) ? 256 : int'(len);
    sum = int'(addr[15:8]) + int'(addr[7:0]) + int'(len);
    applyStimulus(8'hA5);
    applyIdle(syncGap);
    applyStimulus(addr[15:8]);
    applyIdle($urandom_range(0, maxGap));
    applyStimulus(addr[7:0]);
    applyIdle($urandom_range(0, maxGap));
    applyStimulus(len);
    for (int i = 0; i < n; i++) begin
      applyIdle($urandom_range(0, maxGap));
      applyStimulus(frameData[i]);
      sum += int'(frameData[i]);
    end
    applyIdle($urandom_range(0, maxGap));
    applyStimulus(8'(((256 - (sum % 256)) % 256) ^ corrupt));
    applyIdle(3);
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, "_errcnt"}, int'(errCount), mErrCnt);
    checkOutput({name, "_busy"}, int'(busy), 0);
  endtask

  task automatic checkEvent(input int kind);
    ev_t e;
    if (expQ.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
    end else begin
      e = expQ.pop_front();
      checkOutput("event_kind", kind, e.kind);
      checkOutput("event_cycle", cyc, e.cyc);
      if (kind == 0) begin
        checkOutput("wr_addr", int'(wrAddr), e.addr);
        checkOutput("wr_data", int'(wrData), e.data);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (wrEn === 1'b1)     checkEvent(0);
      if (frameOk === 1'b1)  checkEvent(1);
      if (frameErr === 1'b1) checkEvent(2);
`ifdef UART_LOADER_ACK_EN
      if (txDv === 1'b1) begin
        if (txQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_tx: got byte 0x%0h at cycle %0d, expected none", txByte, cyc);
        end else begin
          ev_t t;
          t = txQ.pop_front();
          checkOutput("tx_cycle", cyc, t.cyc);
          checkOutput("tx_byte", int'(txByte), t.data);
        end
      end
`endif
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    dv = 1'b0;
    rxByte = 8'h00;
`ifdef UART_LOADER_ACK_EN
    txActive = 1'b0;
`endif
    applyReset();
    checkOutput("reset_wr_en", int'(wrEn), 0);
    checkOutput("reset_wr_addr", int'(wrAddr), 0);
    checkOutput("reset_wr_data", int'(wrData), 0);
    checkOutput("reset_frame_ok", int'(frameOk), 0);
    checkOutput("reset_frame_err", int'(frameErr), 0);
    applyIdle(2);

    // Directed good frame and its bad-checksum twin
    frameData = '{8'hAA, 8'hBB, 8'hCC};
    sendFrame(16'h1234, 8'd3, 0, 0, 0);
    checkIdle("good");
    checkOutput("good_addr_hold", int'(wrAddr), 16'h1236);
    checkOutput("good_data_hold", int'(wrData), 8'hCC);
    sendFrame(16'h1234, 8'd3, 1, 0, 0);
    checkIdle("badchk");
    checkOutput("badchk_errcnt_is_1", int'(errCount), 1);

    // LEN=0 payload crossing the top of the address space
    fillData(256);
    sendFrame(16'hFFFF, 8'd0, 0, 0, 0);
    checkIdle("wrap");

    // Idle noise must be ignored
    applyStimulus(8'h00);
    applyStimulus(8'h55);
    applyStimulus(8'hFF);
    applyIdle(4);
    checkIdle("noise");

    // Stalled frame aborts, then a fresh frame starts cleanly
    applyStimulus(8'hA5);
    applyStimulus(8'h10);
    applyIdle(T + 5);
    checkIdle("timeout");
    fillData(2);
    sendFrame(16'h0100, 8'd2, 0, 1, 0);
    checkIdle("after_timeout");

    // Byte arriving exactly on the terminal count still belongs to the frame
    fillData(1);
    sendFrame(16'h4000, 8'd1, 0, 0, T - 1);
    checkIdle("terminal_tie");

    // Reset mid-data: the issued write stands, no status pulse
    applyStimulus(8'hA5);
    applyStimulus(8'h20);
    applyStimulus(8'h00);
    applyStimulus(8'h03);
    applyStimulus(8'h11);
    applyReset();
    applyIdle(2);
    fillData(3);
    sendFrame(16'h2000, 8'd3, 0, 0, 0);
    checkIdle("after_reset");

    // Randomized frames, noise and stalls
    for (int f = 0; f < 30; f++) begin
      int sel;
      int len;
      sel = $urandom_range(0, 9);
      if ($urandom_range(0, 2) == 0) begin
        logic [7:0] nb;
        nb = 8'($urandom_range(0, 255));
        if (nb == 8'hA5) nb = 8'h5A;
        applyStimulus(nb);
        applyIdle($urandom_range(1, 3));
      end
      if (sel == 0) begin
        applyStimulus(8'hA5);
        for (int i = 0; i < int'($urandom_range(0, 5)); i++) applyStimulus(8'($urandom_range(0, 255)));
        applyIdle(T + 2);
      end else begin
        len = (sel == 1) ? 0 : int'($urandom_range(1, 12));
        fillData((len == 0) ? 256 : len);
        sendFrame(16'($urandom_range(0, 65535)), 8'(len),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 255)) : 0,
                  $urandom_range(0, 3), $urandom_range(0, 2));
      end
      checkIdle("random");
    end

`ifdef UART_LOADER_ACK_EN
    // Reply is held while the transmitter is busy and sent on the first free cycle
    @(negedge clk);
    txActive = 1'b1;
    fillData(3);
    sendFrame(16'h3000, 8'd3, 0, 0, 0);
    applyIdle(5);
    checkOutput("tx_held_pending", txQ.size(), 1);
    @(negedge clk);
    txActive = 1'b0;
    if (txQ.size() > 0) txQ[txQ.size() - 1].cyc = cyc + 1;
    applyIdle(3);
    checkOutput("tx_queue_drained", txQ.size(), 0);
`endif

    applyIdle(3);
    checkOutput("expected_queue_drained", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
